// File: rtl/time_of_day_counter_pkg.sv
// Shared definitions for the time-of-day counter slice.
//   set_state_e      : set-time handshake FSM encoding
//   BCD_MAX_*        : two-digit BCD roll-over limits for ss, mm and hh
//   bcd_digit_valid  : true when a 4-bit nibble is a legal BCD digit
//   bcd_in_range     : true when both digits are legal and value <= limit
package time_of_day_counter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CHECK    = 2'd1,
        WAIT_LOW = 2'd2
    } set_state_e;

    localparam logic [7:0] BCD_MAX_SEC = 8'h59;
    localparam logic [7:0] BCD_MAX_MIN = 8'h59;
    localparam logic [7:0] BCD_MAX_HR  = 8'h23;

    function automatic logic bcd_digit_valid(input logic [3:0] digit);
        return digit <= 4'd9;
    endfunction

    // With both digits legal, an unsigned compare of the packed BCD byte
    // orders the same way as the decimal value it encodes.
    function automatic logic bcd_in_range(input logic [7:0] value,
                                          input logic [7:0] max_bcd);
        return bcd_digit_valid(value[7:4]) && bcd_digit_valid(value[3:0])
               && (value <= max_bcd);
    endfunction

endpackage

// File: rtl/time_of_day_counter_if.sv
// Set-time handshake between the set-time front end (master) and the
// time-of-day counter (slave).
//   set_req              : level request to load set_hh/set_mm/set_ss
//   set_hh/set_mm/set_ss : BCD time to load
//   set_ack / set_err    : one-cycle accept / reject pulses
interface time_of_day_counter_if;
    logic       set_req;
    logic [7:0] set_hh;
    logic [7:0] set_mm;
    logic [7:0] set_ss;
    logic       set_ack;
    logic       set_err;

    modport master (
        output set_req, set_hh, set_mm, set_ss,
        input  set_ack, set_err
    );

    modport slave (
        input  set_req, set_hh, set_mm, set_ss,
        output set_ack, set_err
    );
endinterface

// File: rtl/time_of_day_counter_bcd_mod_counter.sv
// Two-digit BCD counter that rolls over from MAX_BCD to 00.
//   clk, rst  : clock, asynchronous active-low reset
//   inc       : advance by one this cycle
//   load      : overwrite with load_val (wins over inc)
//   value     : current registered BCD value
//   carry     : combinational, high when inc rolls MAX_BCD over to 00
module bcd_mod_counter
    import time_of_day_counter_pkg::*;
#(
    parameter logic [7:0] MAX_BCD = BCD_MAX_SEC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic       carry
);

    logic [7:0] value_q;
    logic [7:0] value_d;
    logic       at_max;

    assign at_max = (value_q == MAX_BCD);

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (inc) begin
            if (at_max) begin
                value_d = '0;
            end else if (value_q[3:0] == 4'd9) begin
                value_d = {value_q[7:4] + 4'd1, 4'd0};
            end else begin
                value_d = {value_q[7:4], value_q[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign carry = inc && !load && at_max;

endmodule

// File: rtl/time_of_day_counter.sv
// 24-hour BCD time-of-day counter driven by a timebase strobe.
//   clk, rst       : clock, asynchronous active-low reset
//   tick           : one-cycle timebase strobe, TICKS_PER_SEC per second
//   set_if (slave) : set_req/set_hh/set_mm/set_ss in, set_ack/set_err out
//   hh, mm, ss     : current BCD time
//   sec_pulse      : one cycle per second advance
//   min_pulse      : with sec_pulse when minutes advance
//   hour_pulse     : with sec_pulse when hours advance
//   day_wrap       : with sec_pulse on 23:59:59 -> 00:00:00
module time_of_day_counter
    import time_of_day_counter_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 1000,
    parameter int unsigned PRE_W         = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick,
    time_of_day_counter_if.slave        set_if,
    output logic [7:0]                  hh,
    output logic [7:0]                  mm,
    output logic [7:0]                  ss,
    output logic                        sec_pulse,
    output logic                        min_pulse,
    output logic                        hour_pulse,
    output logic                        day_wrap
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

    set_state_e       state_q;
    logic [7:0]       set_hh_q;
    logic [7:0]       set_mm_q;
    logic [7:0]       set_ss_q;
    logic             set_ack_q;
    logic             set_err_q;
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic             sec_pulse_q;
    logic             min_pulse_q;
    logic             hour_pulse_q;
    logic             day_wrap_q;

    logic             set_valid;
    logic             load;
    logic             sec_adv;
    logic             ss_carry;
    logic             mm_carry;
    logic             hh_carry;

    assign set_valid = bcd_in_range(set_hh_q, BCD_MAX_HR)
                    && bcd_in_range(set_mm_q, BCD_MAX_MIN)
                    && bcd_in_range(set_ss_q, BCD_MAX_SEC);

    // A valid load owns the cycle: a coincident tick is dropped entirely.
    assign load    = (state_q == CHECK) && set_valid;
    assign sec_adv = tick && !load && (pre_q == PRE_LAST);

    always_comb begin
        pre_d = pre_q;
        if (load) begin
            pre_d = '0;
        end else if (tick) begin
            pre_d = sec_adv ? '0 : pre_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q        <= '0;
            sec_pulse_q  <= 1'b0;
            min_pulse_q  <= 1'b0;
            hour_pulse_q <= 1'b0;
            day_wrap_q   <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            sec_pulse_q  <= sec_adv;
            min_pulse_q  <= ss_carry;
            hour_pulse_q <= mm_carry;
            day_wrap_q   <= hh_carry;
        end
    end

    bcd_mod_counter #(.MAX_BCD(BCD_MAX_SEC)) u_ss (
        .clk      (clk),
        .rst      (rst),
        .inc      (sec_adv),
        .load     (load),
        .load_val (set_ss_q),
        .value    (ss),
        .carry    (ss_carry)
    );

    bcd_mod_counter #(.MAX_BCD(BCD_MAX_MIN)) u_mm (
        .clk      (clk),
        .rst      (rst),
        .inc      (ss_carry),
        .load     (load),
        .load_val (set_mm_q),
        .value    (mm),
        .carry    (mm_carry)
    );

    bcd_mod_counter #(.MAX_BCD(BCD_MAX_HR)) u_hh (
        .clk      (clk),
        .rst      (rst),
        .inc      (mm_carry),
        .load     (load),
        .load_val (set_hh_q),
        .value    (hh),
        .carry    (hh_carry)
    );

    // Set handshake: capture in IDLE, judge in CHECK, then hold off in
    // WAIT_LOW so a level request yields exactly one ack or err.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            set_hh_q  <= '0;
            set_mm_q  <= '0;
            set_ss_q  <= '0;
            set_ack_q <= 1'b0;
            set_err_q <= 1'b0;
        end else begin
            set_ack_q <= 1'b0;
            set_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (set_if.set_req) begin
                        set_hh_q <= set_if.set_hh;
                        set_mm_q <= set_if.set_mm;
                        set_ss_q <= set_if.set_ss;
                        state_q  <= CHECK;
                    end
                end
                CHECK: begin
                    set_ack_q <= set_valid;
                    set_err_q <= !set_valid;
                    state_q   <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!set_if.set_req) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign set_if.set_ack = set_ack_q;
    assign set_if.set_err = set_err_q;
    assign sec_pulse      = sec_pulse_q;
    assign min_pulse      = min_pulse_q;
    assign hour_pulse     = hour_pulse_q;
    assign day_wrap       = day_wrap_q;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Scoreboard bench for time_of_day_counter: two instances, one with
// TICKS_PER_SEC=4 (dut0) and one with TICKS_PER_SEC=1 (dut1). A model that
// keeps time as seconds-of-day predicts each cycle's outputs.
module tb_time_of_day_counter;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
        logic       sec;
        logic       mn;
        logic       hr;
        logic       day;
        logic       ack;
        logic       err;
    } obs_t;

    typedef struct {
        int    d;
        obs_t  exp;
        string tag;
    } sb_t;

    logic clk = 1'b0;
    logic rst;
    logic tick4, tick1;
    logic [7:0] hh4, mm4, ss4, hh1, mm1, ss1;
    logic sec4, min4, hr4, day4, sec1, min1, hr1, day1;

    time_of_day_counter_if if4 ();
    time_of_day_counter_if if1 ();

    time_of_day_counter #(.TICKS_PER_SEC(4), .PRE_W(3)) dut4 (
        .clk(clk), .rst(rst), .tick(tick4), .set_if(if4),
        .hh(hh4), .mm(mm4), .ss(ss4),
        .sec_pulse(sec4), .min_pulse(min4), .hour_pulse(hr4), .day_wrap(day4)
    );

    time_of_day_counter #(.TICKS_PER_SEC(1), .PRE_W(1)) dut1 (
        .clk(clk), .rst(rst), .tick(tick1), .set_if(if1),
        .hh(hh1), .mm(mm1), .ss(ss1),
        .sec_pulse(sec1), .min_pulse(min1), .hour_pulse(hr1), .day_wrap(day1)
    );

    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;
    sb_t sbq[$];

    // Model state per instance
    int         tps   [2] = '{4, 1};
    int         tod   [2];
    int         pre   [2];
    int         ms    [2];   // 0 idle, 1 check, 2 wait-low
    logic [7:0] cap_h [2];
    logic [7:0] cap_m [2];
    logic [7:0] cap_s [2];

    int sec_cnt0 = 0, min_cnt0 = 0, day_cnt0 = 0, ack_cnt0 = 0, err_cnt0 = 0;

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic int from_bcd(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic bit time_ok(input logic [7:0] h, input logic [7:0] m,
                                   input logic [7:0] s);
        if (h[7:4] > 9 || h[3:0] > 9 || m[7:4] > 9 || m[3:0] > 9 ||
            s[7:4] > 9 || s[3:0] > 9) return 1'b0;
        return (from_bcd(h) <= 23) && (from_bcd(m) <= 59) && (from_bcd(s) <= 59);
    endfunction

    function automatic obs_t observe(input int d);
        obs_t o;
        if (d == 0) begin
            o.hh = hh4; o.mm = mm4; o.ss = ss4;
            o.sec = sec4; o.mn = min4; o.hr = hr4; o.day = day4;
            o.ack = if4.set_ack; o.err = if4.set_err;
        end else begin
            o.hh = hh1; o.mm = mm1; o.ss = ss1;
            o.sec = sec1; o.mn = min1; o.hr = hr1; o.day = day1;
            o.ack = if1.set_ack; o.err = if1.set_err;
        end
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("%h:%h:%h sec=%b min=%b hr=%b day=%b ack=%b err=%b",
                         o.hh, o.mm, o.ss, o.sec, o.mn, o.hr, o.day, o.ack, o.err);
    endfunction

    task automatic model_reset();
        for (int e = 0; e < 2; e++) begin
            tod[e] = 0; pre[e] = 0; ms[e] = 0;
        end
    endtask

    // One clock of the reference model for instance e.
    task automatic model_cycle(input int e, input logic tk, input logic rq,
                               input logic [7:0] h, input logic [7:0] m,
                               input logic [7:0] s, output obs_t o);
        bit loaded = 1'b0;
        o = '0;
        if (ms[e] == 1) begin
            if (time_ok(cap_h[e], cap_m[e], cap_s[e])) begin
                loaded  = 1'b1;
                o.ack   = 1'b1;
                tod[e]  = from_bcd(cap_h[e]) * 3600 + from_bcd(cap_m[e]) * 60
                          + from_bcd(cap_s[e]);
                pre[e]  = 0;
            end else begin
                o.err = 1'b1;
            end
        end
        if (!loaded && tk) begin
            pre[e]++;
            if (pre[e] == tps[e]) begin
                pre[e] = 0;
                tod[e] = (tod[e] + 1) % 86400;
                o.sec  = 1'b1;
                o.mn   = (tod[e] % 60) == 0;
                o.hr   = (tod[e] % 3600) == 0;
                o.day  = tod[e] == 0;
            end
        end
        case (ms[e])
            0: if (rq) begin
                   ms[e] = 1; cap_h[e] = h; cap_m[e] = m; cap_s[e] = s;
               end
            1: ms[e] = 2;
            default: if (!rq) ms[e] = 0;
        endcase
        o.hh = to_bcd(tod[e] / 3600);
        o.mm = to_bcd((tod[e] / 60) % 60);
        o.ss = to_bcd(tod[e] % 60);
    endtask

    // Drive instance d for one cycle (the other sits idle), queue the
    // predictions for both, then compare after the edge.
    task automatic step(input int d, input logic tk, input logic rq,
                        input logic [7:0] h, input logic [7:0] m,
                        input logic [7:0] s, input string tag);
        sb_t  item;
        obs_t got;
        tick4 = (d == 0) ? tk : 1'b0;
        tick1 = (d == 1) ? tk : 1'b0;
        if4.set_req = (d == 0) ? rq : 1'b0;
        if1.set_req = (d == 1) ? rq : 1'b0;
        if4.set_hh = h; if4.set_mm = m; if4.set_ss = s;
        if1.set_hh = h; if1.set_mm = m; if1.set_ss = s;
        for (int e = 0; e < 2; e++) begin
            item.d   = e;
            item.tag = tag;
            model_cycle(e, (e == d) ? tk : 1'b0, (e == d) ? rq : 1'b0,
                        h, m, s, item.exp);
            sbq.push_back(item);
        end
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            item = sbq.pop_front();
            got  = observe(item.d);
            nchk++;
            assert (got === item.exp) else begin
                nerr++;
                $error("FAIL %s dut%0d: observed %s expected %s",
                       item.tag, item.d, fmt(got), fmt(item.exp));
            end
        end
        if (sec4)        sec_cnt0++;
        if (min4)        min_cnt0++;
        if (day4)        day_cnt0++;
        if (if4.set_ack) ack_cnt0++;
        if (if4.set_err) err_cnt0++;
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        obs_t got;
        for (int e = 0; e < 2; e++) begin
            got = observe(e);
            nchk++;
            assert (got === obs_t'('0)) else begin
                nerr++;
                $error("FAIL %s dut%0d: observed %s expected %s",
                       tag, e, fmt(got), fmt(obs_t'('0)));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bad_h [3] = '{8'h24, 8'h12, 8'h1A};
        logic [7:0] bad_m [3] = '{8'h00, 8'h60, 8'h00};
        logic [7:0] hr_pre [2] = '{8'h09, 8'h19};

        rst = 1'b0;
        tick4 = 1'b0; tick1 = 1'b0;
        if4.set_req = 1'b0; if1.set_req = 1'b0;
        if4.set_hh = '0; if4.set_mm = '0; if4.set_ss = '0;
        if1.set_hh = '0; if1.set_mm = '0; if1.set_ss = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        rst = 1'b1;
        model_reset();

        // 240 consecutive ticks at 4 ticks/s
        for (int i = 0; i < 240; i++) step(0, 1'b1, 1'b0, '0, '0, '0, "count240");
        check_int("sec_pulse_count", sec_cnt0, 60);
        check_int("min_pulse_count", min_cnt0, 1);
        check_int("time_after_240", int'({hh4, mm4, ss4}), int'(24'h000100));

        // Load 23:59:59, then one second of ticks wraps the day
        step(0, 1'b0, 1'b1, 8'h23, 8'h59, 8'h59, "load_2359_req");
        step(0, 1'b0, 1'b1, 8'h23, 8'h59, 8'h59, "load_2359_check");
        step(0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, "load_2359_release");
        for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0, '0, '0, '0, "day_wrap_ticks");
        check_int("day_wrap_count", day_cnt0, 1);

        // Rejected loads with ticks running throughout
        for (int b = 0; b < 3; b++) begin
            step(0, 1'b1, 1'b1, bad_h[b], bad_m[b], 8'h00, "bad_req");
            step(0, 1'b1, 1'b1, bad_h[b], bad_m[b], 8'h00, "bad_check");
            step(0, 1'b1, 1'b1, bad_h[b], bad_m[b], 8'h00, "bad_wait");
            step(0, 1'b1, 1'b0, bad_h[b], bad_m[b], 8'h00, "bad_release");
        end
        check_int("err_count", err_cnt0, 3);
        step(0, 1'b1, 1'b0, '0, '0, '0, "pre_offset");
        step(0, 1'b1, 1'b0, '0, '0, '0, "pre_offset");

        // Held request: one ack, prescaler cleared by the load
        for (int i = 0; i < 20; i++) step(0, 1'b0, 1'b1, 8'h12, 8'h34, 8'h56, "held_req");
        check_int("ack_count_held", ack_cnt0, 2);
        step(0, 1'b0, 1'b0, '0, '0, '0, "held_release");
        for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0, '0, '0, '0, "after_load_ticks");

        // Hour units roll-over at 09 -> 10 and 19 -> 20
        for (int k = 0; k < 2; k++) begin
            step(0, 1'b0, 1'b1, hr_pre[k], 8'h59, 8'h59, "hr_roll_req");
            step(0, 1'b0, 1'b1, hr_pre[k], 8'h59, 8'h59, "hr_roll_check");
            step(0, 1'b0, 1'b0, '0, '0, '0, "hr_roll_release");
            for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0, '0, '0, '0, "hr_roll_ticks");
        end
        check_int("ack_count_total", ack_cnt0, 4);

        // TICKS_PER_SEC=1: tick on the load cycle is discarded
        step(1, 1'b0, 1'b1, 8'h08, 8'h15, 8'h30, "t1_req");
        step(1, 1'b1, 1'b1, 8'h08, 8'h15, 8'h30, "t1_check_tick");
        step(1, 1'b1, 1'b0, '0, '0, '0, "t1_next_tick");
        step(1, 1'b1, 1'b0, '0, '0, '0, "t1_next_tick");

        // Asynchronous reset mid-count at 05:06:07
        step(0, 1'b0, 1'b1, 8'h05, 8'h06, 8'h07, "rst_load_req");
        step(0, 1'b0, 1'b1, 8'h05, 8'h06, 8'h07, "rst_load_check");
        step(0, 1'b1, 1'b0, '0, '0, '0, "rst_pre_tick");
        step(0, 1'b1, 1'b0, '0, '0, '0, "rst_pre_tick");
        tick4 = 1'b0; tick1 = 1'b0;
        if4.set_req = 1'b0; if1.set_req = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0, '0, '0, '0, "resume_ticks");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
